link_train_ctrl: RTL
====================

LINK_TRAIN_CTRL -- requirements
Module: link_train_ctrl

Interface
REQ-001 Parameter LBT_CYCLES, 8: consecutive quiet-line cycles required in LBT before handshaking.
REQ-002 Parameter HS_TIMEOUT, 16: cycles allowed in HS_0 or HS_1 without response.
REQ-003 Parameter MAX_RETRY, 3: retries allowed before FAIL; 4-bit range, 0..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin or restart training; honoured only in IDLE or FAIL.
REQ-007 abort  in  1  return to IDLE from any state.
REQ-008 line_busy  in  1  channel activity indication.
REQ-009 hs_ack  in  1  peer acknowledge of current handshake phase.
REQ-010 hs_nack  in  1  peer reject of current handshake phase.
REQ-011 tx_hs0  out  1  drive handshake phase 0; high only in HS_0.
REQ-012 tx_hs1  out  1  drive handshake phase 1; high only in HS_1.
REQ-013 link_up  out  1  high only in UP.
REQ-014 fail  out  1  high only in FAIL.
REQ-015 state  out  3  current state encoding.
REQ-016 retry_cnt  out  4  retries consumed in the current training attempt.

Function
REQ-017 The block SHALL have states IDLE=0, LBT=1, HS_0=2, HS_1=3, UP=4, FAIL=5; codes 6-7 SHALL decode to IDLE on the next cycle.
REQ-018 All outputs SHALL be Moore outputs decoded from the registered state and registered retry_cnt, so they follow a transition by one cycle.
REQ-019 IDLE: start=1 SHALL move to LBT, clear retry_cnt and load the quiet counter with 0.
REQ-020 LBT: line_busy=1 SHALL clear the quiet counter; LBT_CYCLES consecutive line_busy=0 samples SHALL move to HS_0 on the following edge.
REQ-021 HS_0 and HS_1: the timeout counter SHALL load 0 on entry and increment each cycle without response; timeout fires when the count reaches HS_TIMEOUT-1 with no response.
REQ-022 HS_0 with hs_ack=1 SHALL move to HS_1; HS_1 with hs_ack=1 SHALL move to UP.
REQ-023 hs_nack or timeout in HS_0/HS_1 SHALL cause a retry: if retry_cnt==MAX_RETRY move to FAIL, else increment retry_cnt and move to LBT.
REQ-024 Simultaneous hs_ack and hs_nack SHALL be treated as nack; hs_ack on the timeout cycle SHALL be treated as ack.
REQ-025 UP SHALL hold until abort; hs_ack, hs_nack and line_busy SHALL be ignored in UP.
REQ-026 FAIL SHALL hold; start=1 SHALL move to LBT with retry_cnt cleared.
REQ-027 abort=1 SHALL move any state to IDLE next cycle and take priority over all other inputs; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-028 start SHALL be ignored in LBT, HS_0, HS_1 and UP.
REQ-029 retry_cnt SHALL saturate and never wrap; hs_ack/hs_nack outside HS_0/HS_1 SHALL have no effect.

Reset
REQ-030 rst=1 SHALL force state=IDLE, retry_cnt=0, counters=0, tx_hs0=tx_hs1=link_up=fail=0 on the next edge, including mid-handshake, with priority over abort.

Structure
REQ-031 The state encoding, state type and the default values of LBT_CYCLES, HS_TIMEOUT and MAX_RETRY SHALL live in package link_train_pkg.
REQ-032 A single sub-module, link_train_timer, SHALL hold a clearable up-counter with a terminal-count compare, shared by the LBT quiet count and the handshake timeout.

Verification (LBT_CYCLES=8, HS_TIMEOUT=16, MAX_RETRY=3)
REQ-033 start, line quiet, ack 3 cycles into each HS phase -> tx_hs0 rises 9 cycles after start, then link_up=1, retry_cnt=0.
REQ-034 line_busy pulsed at quiet cycle 5 -> HS_0 entered only after 8 further consecutive quiet cycles.
REQ-035 no ack ever -> 4 timeouts in total, retry_cnt reaches 3, then fail=1 and state=5.
REQ-036 hs_ack and hs_nack together in HS_1 -> state=LBT and retry_cnt increments by 1.
REQ-037 rst asserted in HS_1 with retry_cnt=2 -> next cycle state=0, all outputs 0.
REQ-038 abort in UP, then start in FAIL -> IDLE; LBT with retry_cnt=0.

Source files
------------

// File: rtl/link_train_pkg.sv
// Shared types and default timing parameters for the link training controller.
package link_train_pkg;

    localparam int unsigned LBT_CYCLES_DEF = 8;
    localparam int unsigned HS_TIMEOUT_DEF = 16;
    localparam int unsigned MAX_RETRY_DEF  = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LBT  = 3'd1,
        ST_HS_0 = 3'd2,
        ST_HS_1 = 3'd3,
        ST_UP   = 3'd4,
        ST_FAIL = 3'd5
    } state_t;

endpackage

// File: rtl/link_train_timer.sv
// Clearable up-counter with terminal-count compare; shared by the quiet-line
// count and the handshake timeout.
module link_train_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] tc,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign done = (count == tc);

endmodule

// File: rtl/link_train_ctrl.sv
// Link training controller: listen-before-talk, two-phase handshake with
// retries, then UP or FAIL. All outputs are registered Moore decodes.
module link_train_ctrl
    import link_train_pkg::*;
#(
    parameter int unsigned LBT_CYCLES = LBT_CYCLES_DEF,
    parameter int unsigned HS_TIMEOUT = HS_TIMEOUT_DEF,
    parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       line_busy,
    input  logic       hs_ack,
    input  logic       hs_nack,
    output logic       tx_hs0,
    output logic       tx_hs1,
    output logic       link_up,
    output logic       fail,
    output logic [2:0] state,
    output logic [3:0] retry_cnt
);

    localparam int unsigned TC_MAX = (LBT_CYCLES > HS_TIMEOUT) ? LBT_CYCLES : HS_TIMEOUT;
    localparam int unsigned TW     = $clog2(TC_MAX + 1);
    localparam logic [TW-1:0] TC_LBT    = TW'(LBT_CYCLES);
    localparam logic [TW-1:0] TC_HS     = TW'(HS_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    state_t     cur;
    state_t     nxt;
    logic [3:0] retry_q;
    logic [3:0] retry_nxt;
    logic       t_inc;
    logic       t_clr;
    logic       t_done;
    logic [TW-1:0] t_tc;

    link_train_timer #(.W(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (t_clr),
        .inc  (t_inc),
        .tc   (t_tc),
        .done (t_done)
    );

    // The timer only advances on explicit increment; every other cycle clears
    // it, so each entry into LBT or a handshake phase starts from zero.
    always_comb begin
        nxt       = cur;
        retry_nxt = retry_q;
        t_inc     = 1'b0;
        t_tc      = (cur == ST_LBT) ? TC_LBT : TC_HS;
        if (abort) begin
            nxt = ST_IDLE;
        end else begin
            case (cur)
                ST_IDLE, ST_FAIL: begin
                    if (start) begin
                        nxt       = ST_LBT;
                        retry_nxt = '0;
                    end
                end
                ST_LBT: begin
                    if (t_done) begin
                        nxt = ST_HS_0;
                    end else if (!line_busy) begin
                        t_inc = 1'b1;
                    end
                end
                ST_HS_0, ST_HS_1: begin
                    if (hs_nack || (!hs_ack && t_done)) begin
                        if (retry_q == RETRY_MAX) begin
                            nxt = ST_FAIL;
                        end else begin
                            nxt = ST_LBT;
                            if (retry_q != '1) begin
                                retry_nxt = retry_q + 4'd1;
                            end
                        end
                    end else if (hs_ack) begin
                        nxt = (cur == ST_HS_0) ? ST_HS_1 : ST_UP;
                    end else begin
                        t_inc = 1'b1;
                    end
                end
                ST_UP: begin
                end
                default: nxt = ST_IDLE;
            endcase
        end
        t_clr = !t_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= ST_IDLE;
            retry_q <= '0;
            tx_hs0  <= 1'b0;
            tx_hs1  <= 1'b0;
            link_up <= 1'b0;
            fail    <= 1'b0;
        end else begin
            cur     <= nxt;
            retry_q <= retry_nxt;
            tx_hs0  <= (nxt == ST_HS_0);
            tx_hs1  <= (nxt == ST_HS_1);
            link_up <= (nxt == ST_UP);
            fail    <= (nxt == ST_FAIL);
        end
    end

    assign state     = cur;
    assign retry_cnt = retry_q;

endmodule
